// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential divider and its BCD converter.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int bcd_width(input int n);
    return (n / 3 + 1) * 4;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational double-dabble binary to packed BCD converter, digit 0 in bits [3:0].
// Shared between the sequential multiplier and divider.
module bin2bcd
  import divider_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]            bin,
  output logic [bcd_width(N)-1:0] bcd
);

  localparam int BW = bcd_width(N);
  localparam int ND = BW / 4;

  logic [BW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      for (int d = 0; d < ND; d++) begin
        if (acc[d*4 +: 4] >= 4'd5) acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      acc = {acc[BW-2:0], bin[i]};
    end
    bcd = acc;
  end

endmodule

// File: rtl/seq_divider.sv
// N-bit unsigned restoring divider, one quotient bit per clock.
// Optional packed-BCD quotient output enabled by DIVIDER_BCD_EN.
module seq_divider
  import divider_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            a_in,
  input  logic [N-1:0]            b_in,
  input  logic                    start,
  output logic [N-1:0]            quotient,
  output logic [N-1:0]            remainder,
  output logic                    finish,
  output logic                    div_zero,
`ifdef DIVIDER_BCD_EN
  output logic [bcd_width(N)-1:0] bcd,
`endif
  output state_t                  dbg_state
);

  localparam int CW = cnt_width(N);

  // Handshake: start is a level request; a rising edge with start=1 in IDLE
  // launches. finish stays high in DONE until start drops, so a controller
  // holding start high sees exactly one result and never relaunches.

  state_t          state, state_next;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    d_reg;
  logic [N-1:0]    p_reg;
  logic [CW-1:0]   cnt;

  logic            launch;
  logic            step;
  logic            load_result;
  logic [N:0]      p_shift;
  logic [N:0]      diff;
  logic            ge;
  logic [N-1:0]    p_next;
  logic [N-1:0]    a_next;
  logic [N-1:0]    q_load;
  logic [N-1:0]    r_load;
  logic            dz_load;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = RUN;
      RUN:     if (load_result) state_next = DONE;
      DONE:    if (!start)      state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    finish    = (state == DONE);
    launch    = (state == IDLE) && start;
    step      = (state == RUN);
    dbg_state = state;
  end

  // A zero divisor still takes one RUN cycle so the result lands at E+1.
  assign dz_load     = (d_reg == '0);
  assign load_result = step && (dz_load || (cnt == '0));

  // The extra top bit keeps the shifted partial remainder comparable to D.
  assign p_shift = {p_reg, a_reg[N-1]};
  assign diff    = p_shift - {1'b0, d_reg};
  assign ge      = ~diff[N];
  assign p_next  = ge ? diff[N-1:0] : p_shift[N-1:0];
  assign a_next  = {a_reg[N-2:0], ge};
  assign q_load  = dz_load ? '1 : a_next;
  assign r_load  = dz_load ? a_reg : p_next;

`ifdef DIVIDER_BCD_EN
  logic [bcd_width(N)-1:0] bcd_load;

  bin2bcd #(.N(N)) u_bin2bcd (
    .bin (q_load),
    .bcd (bcd_load)
  );

  always_ff @(posedge clk) begin
    if (reset)            bcd <= '0;
    else if (load_result) bcd <= bcd_load;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      d_reg     <= '0;
      p_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      if (launch) begin
        a_reg    <= a_in;
        d_reg    <= b_in;
        p_reg    <= '0;
        cnt      <= CW'(N - 1);
        div_zero <= 1'b0;
      end else if (step && !dz_load) begin
        a_reg <= a_next;
        p_reg <= p_next;
        cnt   <= cnt - CW'(1);
      end
      if (load_result) begin
        quotient  <= q_load;
        remainder <= r_load;
        div_zero  <= dz_load;
      end
    end
  end

endmodule
